bp_me_stream_pump_out_wrap: RTL
===============================

Name: bp_me_stream_pump_out_wrap

Overview:
- Upstream feeder for the burst-count generator. Accepts one full BedRock-style message (address, size, block-width payload) on a valid/ready-and interface and emits it as a wrapped stream of beat-width beats.
- Each emitted beat carries its own beat address and first/last flags.
- Holds one message in a local register. Sequences beats with an internal wrap counter, so downstream network and memory stages see a critical-word-first burst.

Parameters:
- block_width_p, 512, payload width in bits; block_width_p/beat_width_p is a power of two.
- beat_width_p, 64, stream beat width in bits; power of two, >= 8.
- addr_width_p, 40, address width in bits.
- max_val_lp (local), block_width_p/beat_width_p-1, zero-based beats per block.
- cnt_width_lp (local), `BSG_SAFE_CLOG2(max_val_lp+1).
- beat_off_lp (local), log2(beat_width_p/8), byte-offset bits within a beat.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- in_v_i  in  1  message valid
- in_ready_and_o  out  1  message accepted when in_v_i & in_ready_and_o
- in_addr_i  in  addr_width_p  byte address (critical word)
- in_size_i  in  3  log2(bytes); legal transaction <= block bytes
- in_data_i  in  block_width_p  payload, LSB-justified
- out_v_o  out  1  beat valid
- out_ready_and_i  in  1  beat consumed when out_v_o & out_ready_and_i
- out_addr_o  out  addr_width_p  beat address
- out_data_o  out  beat_width_p  beat data
- out_first_o  out  1  first beat of message
- out_last_o  out  1  last beat of message

Behaviour:
- Reset is synchronous and active-low: one clock; while reset_n_i=0 at a clock edge, busy_r<=0 and the pump counter returns to ready.
- Outputs during reset: in_ready_and_o=0, out_v_o=0, out_first_o=1, out_last_o=1 for a single-beat message, otherwise 0. out_addr_o and out_data_o are don't-care.
- Reset mid-burst discards the remaining beats. No partial state survives.
- States: IDLE (busy_r=0) and SEND (busy_r=1).
- IDLE: in_ready_and_o=1 and out_v_o=0. An input handshake latches addr, size and data, and moves to SEND next cycle. Input-to-first-beat latency is 1 cycle.
- SEND: out_v_o=1. Each output handshake advances the counter.
- The last-beat handshake returns to IDLE, unless a new message is accepted in that same cycle, in which case the block stays in SEND with the new message.
- in_ready_and_o = ~busy_r | (out_v_o & out_ready_and_i & out_last_o), and is 0 in reset. Back-to-back messages therefore have no bubble.
- Beat count: beats-1 = (2^size >> beat_off_lp) - 1, floored at 0, so size <= beat_off_lp gives one beat. Width is cnt_width_lp.
- Initial beat index = addr_r[beat_off_lp +: cnt_width_lp].
- Wrap index w wraps within the naturally aligned sub-block of 2^size bytes:
  - bits of w at positions where size_beats-1 >= 2^i come from the counter;
  - the remaining bits come from the initial index.
- out_addr_o:
  - first beat: addr_r unchanged;
  - later beats: {addr_r upper bits, w, beat_off_lp'b0}.
- out_data_o:
  - multi-beat: data_r[(w & (beats-1))*beat_width_p +: beat_width_p];
  - single-beat with size < beat_off_lp: the low 2^size bytes of data_r replicated across the beat;
  - single-beat with size == beat_off_lp: data_r low beat.
- out_first_o=1 on the first beat only; out_last_o=1 on the final beat only. Both are 1 for single-beat messages.
- Backpressure: with out_ready_and_i=0, all out_* outputs hold stable.
- Illegal size > block bytes is an assertion failure in simulation. The RTL clamps it to a full block.

Decomposition:
- Shared package: the size-code typedef (3-bit log2 bytes) and a beats-from-size function. No other typedefs needed.
- Sub-module: bp_me_burst_pump_control (max_val_p=max_val_lp), instantiated with reset_i = ~reset_n_i.
  - en_i = out handshake;
  - size_i = beats-1;
  - val_i = initial index;
  - its wrap/first/last outputs drive w, out_first_o and out_last_o.
- Data select and replication are local mux logic.

Test Plan:
- Full block, size=6 (64B), addr=0x1010 -> 8 beats, out_addr 0x1010,0x1018,0x1020..0x1038,0x1000,0x1008; data indices 2..7,0,1; first on beat 0, last on beat 7.
- Half block, size=5 (32B), addr=0x1030 -> 4 beats, indices 6,7,4,5, addr 0x1030,0x1038,0x1020,0x1028; data indices (w&3) = 2,3,0,1.
- Sub-beat, size=1 (2B), addr=0x1006, data low=0xBEEF -> 1 beat, first=last=1, out_data=0xBEEFBEEFBEEFBEEF, out_addr=0x1006.
- Backpressure: out_ready_and_i random 50% during a size=6 message -> outputs hold while stalled, exactly 8 handshakes, same sequence as the first scenario.
- Back-to-back: second message valid during the first's last beat -> accepted that cycle, its first beat appears the next cycle, no idle cycle.
- Reset mid-burst: reset_n_i=0 after beat 3 of 8 -> out_v_o=0 next cycle; after release in_ready_and_o=1; next message starts at its own initial index with first=1.

Source files
------------

// File: rtl/bp_me_stream_pump_out_wrap_pkg.sv
// Shared types and helpers for the wrapped stream pump.
// - bp_size_t  : 3-bit log2(bytes) message size code
// - beats_m1_f : zero-based beat count of a message, floored at 0, capped at a block
// - safe_clog2 : clog2 that never returns 0, for counter widths
package bp_me_stream_pump_out_wrap_pkg;

    typedef logic [2:0] bp_size_t;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int beats_m1_f(input bp_size_t size, input int beat_off, input int max_val);
        int b;
        if (int'(size) <= beat_off) b = 0;
        else                        b = (1 << (int'(size) - beat_off)) - 1;
        return (b > max_val) ? max_val : b;
    endfunction

endpackage

// File: rtl/bp_me_stream_pump_out_wrap_if.sv
// Message-in / beat-out bus of the wrapped stream pump.
// - in_*  : one full message (address, size, block payload), valid/ready-and
// - out_* : wrapped beats with beat address and first/last flags, valid/ready-and
// slave is the pump side, master is the producer/consumer side.
interface bp_me_stream_pump_out_wrap_if #(
    parameter int block_width_p = 512,
    parameter int beat_width_p  = 64,
    parameter int addr_width_p  = 40
);
    import bp_me_stream_pump_out_wrap_pkg::*;

    logic                     in_v_i;
    logic                     in_ready_and_o;
    logic [addr_width_p-1:0]  in_addr_i;
    bp_size_t                 in_size_i;
    logic [block_width_p-1:0] in_data_i;
    logic                     out_v_o;
    logic                     out_ready_and_i;
    logic [addr_width_p-1:0]  out_addr_o;
    logic [beat_width_p-1:0]  out_data_o;
    logic                     out_first_o;
    logic                     out_last_o;

    modport slave (
        input  in_v_i, in_addr_i, in_size_i, in_data_i, out_ready_and_i,
        output in_ready_and_o, out_v_o, out_addr_o, out_data_o, out_first_o, out_last_o
    );

    modport master (
        output in_v_i, in_addr_i, in_size_i, in_data_i, out_ready_and_i,
        input  in_ready_and_o, out_v_o, out_addr_o, out_data_o, out_first_o, out_last_o
    );

endinterface

// File: rtl/bp_me_burst_pump_control.sv
// Burst beat counter with wrap-index generation.
// - clk_i, reset_i (sync, active-high)
// - en_i    : advance one beat
// - size_i  : zero-based beat count of the burst
// - val_i   : starting beat index within the block
// - wrap_o  : current beat index, wrapped inside the size-aligned sub-block
// - first_o / last_o : current beat is the first / final one
module bp_me_burst_pump_control
    import bp_me_stream_pump_out_wrap_pkg::*;
#(
    parameter  int max_val_p    = 7,
    localparam int cnt_width_lp = safe_clog2(max_val_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic [cnt_width_lp-1:0] size_i,
    input  logic [cnt_width_lp-1:0] val_i,
    output logic [cnt_width_lp-1:0] wrap_o,
    output logic                    first_o,
    output logic                    last_o
);

    logic [cnt_width_lp-1:0] cnt_r;
    logic [cnt_width_lp-1:0] sum;

    assign first_o = (cnt_r == '0);
    assign last_o  = (cnt_r == size_i);
    assign sum     = val_i + cnt_r;

    // Bits covered by the burst length advance from the start index; the
    // rest pin the burst inside its naturally aligned sub-block.
    always_comb begin
        wrap_o = val_i;
        for (int i = 0; i < cnt_width_lp; i++)
            if (int'(size_i) >= (1 << i)) wrap_o[i] = sum[i];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)    cnt_r <= '0;
        else if (en_i)  cnt_r <= last_o ? '0 : cnt_r + cnt_width_lp'(1);
    end

endmodule

// File: rtl/bp_me_stream_pump_out_wrap.sv
// Wrapped stream pump: latches one block message and emits it as a
// critical-word-first burst of beats.
// - clk_i     : clock
// - reset_n_i : synchronous active-low reset
// - io        : message in / beat out bus (slave side)
module bp_me_stream_pump_out_wrap
    import bp_me_stream_pump_out_wrap_pkg::*;
#(
    parameter int block_width_p = 512,
    parameter int beat_width_p  = 64,
    parameter int addr_width_p  = 40
) (
    input logic                          clk_i,
    input logic                          reset_n_i,
    bp_me_stream_pump_out_wrap_if.slave  io
);

    localparam int max_val_lp    = block_width_p / beat_width_p - 1;
    localparam int cnt_width_lp  = safe_clog2(max_val_lp + 1);
    localparam int beat_off_lp   = $clog2(beat_width_p / 8);
    localparam int beat_bytes_lp = beat_width_p / 8;
    localparam int block_size_lp = $clog2(block_width_p / 8);
    localparam int hi_lsb_lp     = beat_off_lp + cnt_width_lp;

    logic                     busy_r;
    logic [addr_width_p-1:0]  addr_r;
    bp_size_t                 size_r;
    logic [block_width_p-1:0] data_r;

    logic                     in_hs, out_hs;
    bp_size_t                 size_clamp;
    logic [cnt_width_lp-1:0]  beats_m1, init_idx, wrap, beat_sel;

    logic [max_val_lp:0][beat_width_p-1:0] data_beats;
    logic [beat_width_p-1:0]               rep_data;

    assign in_hs  = io.in_v_i & io.in_ready_and_o;
    assign out_hs = io.out_v_o & io.out_ready_and_i;

    assign io.out_v_o        = busy_r & reset_n_i;
    // Accepting during the final beat's handshake keeps back-to-back bursts bubble-free.
    assign io.in_ready_and_o = reset_n_i & (~busy_r | (out_hs & io.out_last_o));

    assign size_clamp = (int'(io.in_size_i) > block_size_lp) ? bp_size_t'(block_size_lp)
                                                              : io.in_size_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            busy_r <= 1'b0;
        end else if (in_hs) begin
            busy_r <= 1'b1;
            addr_r <= io.in_addr_i;
            size_r <= size_clamp;
            data_r <= io.in_data_i;
        end else if (out_hs & io.out_last_o) begin
            busy_r <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && in_hs) assert (int'(io.in_size_i) <= block_size_lp);
    end

    assign beats_m1 = cnt_width_lp'(beats_m1_f(size_r, beat_off_lp, max_val_lp));
    assign init_idx = addr_r[beat_off_lp +: cnt_width_lp];

    bp_me_burst_pump_control #(.max_val_p(max_val_lp)) pump (
        .clk_i   (clk_i),
        .reset_i (~reset_n_i),
        .en_i    (out_hs),
        .size_i  (beats_m1),
        .val_i   (init_idx),
        .wrap_o  (wrap),
        .first_o (io.out_first_o),
        .last_o  (io.out_last_o)
    );

    assign io.out_addr_o = io.out_first_o
        ? addr_r
        : {addr_r[addr_width_p-1:hi_lsb_lp], wrap, {beat_off_lp{1'b0}}};

    // Payload is LSB-justified, so a sub-block burst indexes only its low beats.
    assign data_beats = data_r;
    assign beat_sel   = wrap & beats_m1;

    // Single-beat messages narrower than a beat are replicated across the beat.
    always_comb begin
        int m;
        rep_data = '0;
        m = (int'(size_r) >= beat_off_lp) ? beat_bytes_lp - 1 : (1 << int'(size_r)) - 1;
        for (int b = 0; b < beat_bytes_lp; b++)
            rep_data[b*8 +: 8] = data_r[(b & m)*8 +: 8];
    end

    assign io.out_data_o = (beats_m1 != '0) ? data_beats[beat_sel] : rep_data;

endmodule
